// File: rtl/iq_fetch_ctrl_if.sv
// Fetch-side bundle: imem read request/response plus IQ enqueue and redirect.
// master = fetch controller, slave = memory/IQ/redirect environment.
interface iq_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic        iq_enq;
  logic [31:0] iq_pc;
  logic [31:0] iq_inst;
  logic        iq_full;
  logic        flush;
  logic [31:0] flush_pc;

  modport master (
    output imem_req, imem_addr, iq_enq, iq_pc, iq_inst,
    input  imem_resp, imem_rdata, iq_full, flush, flush_pc
  );

  modport slave (
    input  imem_req, imem_addr, iq_enq, iq_pc, iq_inst,
    output imem_resp, imem_rdata, iq_full, flush, flush_pc
  );
endinterface

// File: rtl/iq_fetch_ctrl.sv
// Fetch controller: owns the PC, issues in-order imem reads, feeds {pc, inst} to the IQ; FETCH_PERF_EN adds perf counters.
// Latency: a response reaches iq_enq one cycle after imem_resp at the earliest (registered FIFO, no bypass).
// Backpressure: iq_full stalls enqueue; requests stop once in-flight + buffered words reach MAX_OUT.

module iq_fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         push,
  input  logic [W-1:0]                 push_dat,
  input  logic                         pop,
  output logic [W-1:0]                 head_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage is not reset; readers gate the head with count.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_dat = mem[rd_ptr];
endmodule

module iq_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h6000_0000,
  parameter int          MAX_OUT  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  iq_fetch_ctrl_if.master  bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetched,
  output logic [31:0]      perf_stall
`endif
);
  localparam int CW = $clog2(MAX_OUT+1);

  typedef enum logic [1:0] {IDLE, FETCH, REDIRECT} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] discard;
  logic [CW-1:0] discard_nxt;
  logic [CW:0]   occupancy;

  logic [CW-1:0] tag_count;
  logic [31:0]   tag_head;
  logic [CW-1:0] resp_count;
  logic [63:0]   resp_head;

  logic req;
  logic enq;
  logic resp_keep;
  logic resp_empty;

  always_comb begin
    state_nxt       = state;
    discard_nxt     = discard;
    occupancy       = (CW+1)'(outstanding) + (CW+1)'(resp_count);
    resp_empty      = (resp_count == '0);
    req             = (state == FETCH) && !bus.flush && (occupancy < (CW+1)'(MAX_OUT));
    enq             = !resp_empty && !bus.iq_full && !bus.flush;
    resp_keep       = bus.imem_resp && !bus.flush && (discard == '0);
    outstanding_nxt = outstanding + CW'(req) - CW'(bus.imem_resp);

    // A response arriving with the flush is already excluded from outstanding_nxt.
    if (bus.flush)
      discard_nxt = outstanding_nxt;
    else if (bus.imem_resp && (discard != '0))
      discard_nxt = discard - CW'(1);

    case (state)
      IDLE:     state_nxt = FETCH;
      FETCH:    if (bus.flush && (outstanding_nxt != '0)) state_nxt = REDIRECT;
      REDIRECT: if (discard_nxt == '0) state_nxt = FETCH;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
      if (bus.flush)
        pc <= bus.flush_pc;
      else if (req)
        pc <= pc + 32'd4;
    end
  end

  // PC of each live request, consumed in order by the matching response.
  iq_fetch_fifo #(.W(32), .DEPTH(MAX_OUT)) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (bus.flush),
    .push     (req),
    .push_dat (pc),
    .pop      (resp_keep),
    .head_dat (tag_head),
    .count    (tag_count)
  );

  iq_fetch_fifo #(.W(64), .DEPTH(MAX_OUT)) u_resp_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (bus.flush),
    .push     (resp_keep),
    .push_dat ({tag_head, bus.imem_rdata}),
    .pop      (enq),
    .head_dat (resp_head),
    .count    (resp_count)
  );

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc;
  assign bus.iq_enq    = enq;
  assign bus.iq_pc     = resp_empty ? 32'd0 : resp_head[63:32];
  assign bus.iq_inst   = resp_empty ? 32'd0 : resp_head[31:0];

  // Every in-flight request is either tagged for delivery or pending discard.
  a_inflight_split: assert property (@(posedge clk) disable iff (!rst_n)
    ((CW+1)'(tag_count) + (CW+1)'(discard)) == (CW+1)'(outstanding));

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (enq && (perf_fetched != '1))
        perf_fetched <= perf_fetched + 32'd1;
      if (!resp_empty && bus.iq_full && (perf_stall != '1))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif
endmodule
